// File: rtl/ysyx_22040632_axi_pkg.sv
// rtl/ysyx_22040632_axi_pkg.sv - shared AXI response codes and slave FSM state encoding
// Purpose: constants used by the AXI SRAM slave and its testbench.
// Ports: none (package).
package ysyx_22040632_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 2'd0;
    localparam fsm_state_t ST_WDATA = 2'd1;
    localparam fsm_state_t ST_WRESP = 2'd2;
    localparam fsm_state_t ST_RDATA = 2'd3;

endpackage

// File: rtl/ysyx_22040632_sram_bw.sv
// rtl/ysyx_22040632_sram_bw.sv - single-port byte-writable RAM with registered read
// Purpose: WORDS x DATA_W storage; one access per cycle, write or read.
// Ports:
//   clk    in            clock
//   en     in  1         access enable
//   we     in  1         1 = write strobed bytes, 0 = read into rdata
//   be     in  DATA_W/8  byte enables for writes
//   addr   in  IDX_W     word index
//   wdata  in  DATA_W    write data
//   rdata  out DATA_W    read data, valid the cycle after a read; held otherwise
module ysyx_22040632_sram_bw #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 4096,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    // rdata only updates on a read access, so the slave can stall a beat
    // simply by not enabling the RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// rtl/axi4_sram_slave.sv - AXI4 INCR-burst slave backed by one byte-writable SRAM
// Purpose: main RAM for the core's AXI master; one transaction in flight at a time.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   aw_valid/aw_ready/aw_addr/aw_id/aw_len   write address channel
//   w_valid/w_ready/w_data/w_strb/w_last     write data channel
//   b_valid/b_ready/b_resp/b_id              write response channel
//   ar_valid/ar_ready/ar_addr/ar_id/ar_len   read address channel
//   r_valid/r_ready/r_data/r_resp/r_last/r_id read data channel
module axi4_sram_slave
    import ysyx_22040632_axi_pkg::*;
#(
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_ID_WIDTH   = 4,
    parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE       = 32'h8000_0000,
    parameter int                        MEM_WORDS      = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        aw_valid,
    output logic                        aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [7:0]                  aw_len,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    output logic                        b_valid,
    input  logic                        b_ready,
    output logic [1:0]                  b_resp,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    input  logic                        ar_valid,
    output logic                        ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [7:0]                  ar_len,
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic [AXI_ID_WIDTH-1:0]     r_id
);

    localparam int                        IDX_W     = $clog2(MEM_WORDS);
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_WORDS * 8);

    fsm_state_t                  state;
    logic                        live;      // low only in the first cycle after reset
    logic                        prio_wr;   // side that wins a simultaneous request
    logic                        decerr;
    logic                        over;      // write burst already consumed aw_len+1 beats
    logic [IDX_W-1:0]            base_idx;
    logic [7:0]                  beat;
    logic [7:0]                  len;
    logic [AXI_ID_WIDTH-1:0]     id_q;
    logic [1:0]                  b_resp_q;

    logic [AXI_ADDR_WIDTH-1:0]   aw_off;
    logic [AXI_ADDR_WIDTH-1:0]   ar_off;
    logic                        aw_dec;
    logic                        ar_dec;
    logic                        is_idle;
    logic                        aw_hs;
    logic                        ar_hs;
    logic                        w_hs;
    logic                        last_beat;

    logic                        ram_en;
    logic                        ram_we;
    logic [IDX_W-1:0]            ram_addr;
    logic [AXI_DATA_WIDTH-1:0]   ram_rdata;

    // Unsigned subtraction folds "below base" into a huge offset, so one
    // compare covers both ends of the window.
    assign aw_off = aw_addr - MEM_BASE;
    assign ar_off = ar_addr - MEM_BASE;
    assign aw_dec = (aw_off >= MEM_BYTES);
    assign ar_dec = (ar_off >= MEM_BYTES);

    assign is_idle  = (state == ST_IDLE);
    assign aw_ready = live & is_idle & aw_valid & (~ar_valid | prio_wr);
    assign ar_ready = live & is_idle & ar_valid & (~aw_valid | ~prio_wr);
    assign aw_hs    = aw_valid & aw_ready;
    assign ar_hs    = ar_valid & ar_ready;

    assign w_ready   = (state == ST_WDATA);
    assign w_hs      = w_valid & w_ready;
    assign last_beat = (beat == len);

    assign b_valid = (state == ST_WRESP);
    assign b_resp  = b_resp_q;
    assign b_id    = id_q;

    assign r_valid = (state == ST_RDATA);
    assign r_last  = r_valid & last_beat;
    assign r_resp  = (r_valid & decerr) ? RESP_DECERR : RESP_OKAY;
    assign r_data  = (r_valid & ~decerr) ? ram_rdata : '0;
    assign r_id    = id_q;

    // Single RAM port: the first read word is fetched on the AR handshake,
    // each later one on the handshake of the beat before it.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        if (is_idle && ar_hs) begin
            ram_en   = 1'b1;
            ram_addr = ar_off[IDX_W+2:3];
        end else if (w_hs && !decerr && !over) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = base_idx + IDX_W'(beat);
        end else if (r_valid && r_ready && !last_beat) begin
            ram_en   = 1'b1;
            ram_addr = base_idx + IDX_W'(beat + 8'd1);
        end
    end

    ysyx_22040632_sram_bw #(
        .DATA_W (AXI_DATA_WIDTH),
        .WORDS  (MEM_WORDS),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk    (clk),
        .en     (ram_en),
        .we     (ram_we),
        .be     (w_strb),
        .addr   (ram_addr),
        .wdata  (w_data),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            live     <= 1'b0;
            prio_wr  <= 1'b1;
            decerr   <= 1'b0;
            over     <= 1'b0;
            base_idx <= '0;
            beat     <= '0;
            len      <= '0;
            id_q     <= '0;
            b_resp_q <= RESP_OKAY;
        end else begin
            live <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        state    <= ST_WDATA;
                        base_idx <= aw_off[IDX_W+2:3];
                        len      <= aw_len;
                        id_q     <= aw_id;
                        decerr   <= aw_dec;
                        beat     <= '0;
                        over     <= 1'b0;
                        prio_wr  <= 1'b0;
                    end else if (ar_hs) begin
                        state    <= ST_RDATA;
                        base_idx <= ar_off[IDX_W+2:3];
                        len      <= ar_len;
                        id_q     <= ar_id;
                        decerr   <= ar_dec;
                        beat     <= '0;
                        prio_wr  <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        if (w_last) begin
                            state <= ST_WRESP;
                            if (decerr) begin
                                b_resp_q <= RESP_DECERR;
                            end else if (over || !last_beat) begin
                                b_resp_q <= RESP_SLVERR;
                            end else begin
                                b_resp_q <= RESP_OKAY;
                            end
                        end else if (last_beat) begin
                            over <= 1'b1;
                        end else begin
                            beat <= beat + 8'd1;
                        end
                    end
                end
                ST_WRESP: begin
                    if (b_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (r_ready) begin
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end else begin
                            beat <= beat + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb/tb_axi4_sram_slave.sv - scoreboard testbench for axi4_sram_slave
module tb_axi4_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [31:0] aw_addr = '0;
    logic [3:0]  aw_id = '0;
    logic [7:0]  aw_len = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [31:0] ar_addr = '0;
    logic [3:0]  ar_id = '0;
    logic [7:0]  ar_len = '0;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;

    always #5 clk = ~clk;

    axi4_sram_slave dut (
        .clk(clk), .rst_n(rst_n),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp), .b_id(b_id),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_id(r_id)
    );

    typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;
    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;

    int          checks = 0;
    int          failures = 0;
    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [63:0] mdl [WORDS];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    bit          rand_ready = 1'b0;
    logic        fix_b = 1'b1;
    logic        fix_r = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=handshake", name);
    endtask

    // Reference model: flat word array, index arithmetic straight from the address map.
    function automatic bit is_dec(input logic [31:0] a);
        return (a < BASE) || (a >= BASE + 32'(WORDS * 8));
    endfunction

    function automatic int widx(input logic [31:0] a, input int k);
        return (int'((a - BASE) >> 3) + k) % WORDS;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [3:0] id,
                                        input logic [7:0] len, input int nbeats);
        b_exp_t e;
        if (!is_dec(addr)) begin
            for (int k = 0; k < nbeats && k <= int'(len); k++) begin
                for (int b = 0; b < 8; b++) begin
                    if (ws[k][b]) mdl[widx(addr, k)][b*8 +: 8] = wd[k][b*8 +: 8];
                end
            end
        end
        e.resp = is_dec(addr) ? 2'b11 : (nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
        e.id   = id;
        bq.push_back(e);
    endfunction

    function automatic void model_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        r_exp_t e;
        for (int k = 0; k <= int'(len); k++) begin
            e.data = is_dec(addr) ? 64'd0 : mdl[widx(addr, k)];
            e.resp = is_dec(addr) ? 2'b11 : 2'b00;
            e.last = (k == int'(len));
            e.id   = id;
            rq.push_back(e);
        end
    endfunction

    // Monitor: every accepted B or R beat is popped from the scoreboard and compared.
    always @(negedge clk) begin : monitor
        b_exp_t be;
        r_exp_t re;
        if (rst_n && b_valid && b_ready) begin
            if (bq.size() == 0) chk("b_unexpected", 64'(b_valid), 64'd0);
            else begin
                be = bq.pop_front();
                chk("b_resp", 64'(b_resp), 64'(be.resp));
                chk("b_id", 64'(b_id), 64'(be.id));
            end
        end
        if (rst_n && r_valid && r_ready) begin
            if (rq.size() == 0) chk("r_unexpected", 64'(r_valid), 64'd0);
            else begin
                re = rq.pop_front();
                chk("r_data", r_data, re.data);
                chk("r_resp", 64'(r_resp), 64'(re.resp));
                chk("r_last", 64'(r_last), 64'(re.last));
                chk("r_id", 64'(r_id), 64'(re.id));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) begin
                b_ready = ($urandom_range(0, 3) != 0);
                r_ready = ($urandom_range(0, 2) != 0);
            end else begin
                b_ready = fix_b;
                r_ready = fix_r;
            end
        end
    end

    // which: 0 = AW, 1 = W, 2 = AR. Returns just after the handshake edge.
    task automatic wait_ready(input int which);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((which == 0 && aw_ready) || (which == 1 && w_ready) || (which == 2 && ar_ready)) break;
            n++;
            if (n > 200) begin
                timeout_fail(which == 0 ? "aw_handshake" : which == 1 ? "w_handshake" : "ar_handshake");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (bq.size() != 0 || rq.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                timeout_fail("scoreboard_drain");
                bq.delete();
                rq.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_w(input int nbeats, input bit gaps);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                w_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            w_data  = wd[k];
            w_strb  = ws[k];
            w_last  = (k == nbeats - 1);
            w_valid = 1'b1;
            wait_ready(1);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input int nbeats, input bit gaps);
        model_write(addr, id, len, nbeats);
        aw_addr  = addr;
        aw_id    = id;
        aw_len   = len;
        aw_valid = 1'b1;
        wait_ready(0);
        aw_valid = 1'b0;
        send_w(nbeats, gaps);
        wait_drain();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        model_read(addr, id, len);
        ar_addr  = addr;
        ar_id    = id;
        ar_len   = len;
        ar_valid = 1'b1;
        wait_ready(2);
        ar_valid = 1'b0;
        wait_drain();
    endtask

    task automatic fill(input int n, input bit full);
        for (int k = 0; k < n; k++) begin
            wd[k] = {$urandom, $urandom};
            ws[k] = full ? 8'hFF : 8'($urandom_range(0, 255));
        end
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ra;
    logic [7:0]  rl;
    int          st;
    logic [63:0] hold_d;
    logic        hold_l;
    r_exp_t      man;

    initial begin
        // Reset: all outputs low
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_aw_ready", 64'(aw_ready), 64'd0);
        chk("rst_w_ready", 64'(w_ready), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_b_resp", 64'(b_resp), 64'd0);
        chk("rst_ar_ready", 64'(ar_ready), 64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_r_data", r_data, 64'd0);
        chk("rst_r_last", 64'(r_last), 64'd0);
        chk("rst_r_id", 64'(r_id), 64'd0);
        reset_release();

        // Arbitration: write first after reset, then alternate
        fill(1, 1'b1);
        model_write(BASE + 32'd800, 4'h1, 8'd0, 1);
        aw_addr = BASE + 32'd800; aw_id = 4'h1; aw_len = 8'd0;
        ar_addr = BASE + 32'd800; ar_id = 4'h2; ar_len = 8'd0;
        aw_valid = 1'b1; ar_valid = 1'b1;
        @(negedge clk);
        chk("arb1_aw_ready", 64'(aw_ready), 64'd1);
        chk("arb1_ar_ready", 64'(ar_ready), 64'd0);
        @(posedge clk); #1;
        aw_valid = 1'b0; ar_valid = 1'b0;
        send_w(1, 1'b0);
        wait_drain();
        model_read(BASE + 32'd800, 4'h2, 8'd0);
        aw_valid = 1'b1; ar_valid = 1'b1;
        @(negedge clk);
        chk("arb2_aw_ready", 64'(aw_ready), 64'd0);
        chk("arb2_ar_ready", 64'(ar_ready), 64'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0; ar_valid = 1'b0;
        wait_drain();
        fill(1, 1'b1);
        model_write(BASE + 32'd808, 4'h3, 8'd0, 1);
        aw_addr = BASE + 32'd808; aw_id = 4'h3;
        aw_valid = 1'b1; ar_valid = 1'b1;
        @(negedge clk);
        chk("arb3_aw_ready", 64'(aw_ready), 64'd1);
        chk("arb3_ar_ready", 64'(ar_ready), 64'd0);
        @(posedge clk); #1;
        aw_valid = 1'b0; ar_valid = 1'b0;
        send_w(1, 1'b0);
        wait_drain();

        // Known contents for every word later reads may touch
        fill(64, 1'b1);
        do_write(BASE, 4'h0, 8'd63, 64, 1'b0);
        fill(32, 1'b1);
        do_write(BASE + 32'(4064 * 8), 4'h0, 8'd31, 32, 1'b0);

        // Basic 4-beat burst write and read-back
        fill(4, 1'b1);
        do_write(BASE, 4'h5, 8'd3, 4, 1'b0);
        do_read(BASE, 4'h9, 8'd3);

        // Byte strobes
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        do_write(BASE + 32'd80, 4'h6, 8'd0, 1, 1'b0);
        wd[0] = 64'h1111_2222_3333_4444; ws[0] = 8'h0F;
        do_write(BASE + 32'd80, 4'h6, 8'd0, 1, 1'b0);
        man.data = 64'hFFFF_FFFF_3333_4444; man.resp = 2'b00; man.last = 1'b1; man.id = 4'h7;
        rq.push_back(man);
        ar_addr = BASE + 32'd80; ar_id = 4'h7; ar_len = 8'd0; ar_valid = 1'b1;
        wait_ready(2);
        ar_valid = 1'b0;
        wait_drain();

        // Read latency and r_ready back-pressure
        model_read(BASE + 32'd128, 4'hA, 8'd7);
        ar_addr = BASE + 32'd128; ar_id = 4'hA; ar_len = 8'd7; ar_valid = 1'b1;
        wait_ready(2);
        ar_valid = 1'b0;
        @(negedge clk);
        chk("r_first_latency", 64'(r_valid), 64'd1);
        @(posedge clk); #1;
        fix_r = 1'b0;
        @(negedge clk);
        hold_d = r_data;
        hold_l = r_last;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_r_valid", 64'(r_valid), 64'd1);
            chk("stall_r_data", r_data, hold_d);
            chk("stall_r_last", 64'(r_last), 64'(hold_l));
        end
        fix_r = 1'b1;
        wait_drain();

        // Decode errors and window boundaries
        do_read(32'h1000_0000, 4'hB, 8'd3);
        fill(2, 1'b1);
        do_write(32'h1000_0000, 4'hC, 8'd1, 2, 1'b0);
        do_read(BASE, 4'hD, 8'd1);
        do_read(BASE + 32'h7FF8, 4'h1, 8'd0);
        do_read(BASE + 32'h8000, 4'h2, 8'd1);
        do_read(32'h7FFF_FFF8, 4'h3, 8'd0);

        // Beat-count mismatch: early and late w_last
        fill(3, 1'b1);
        do_write(BASE + 32'd160, 4'h4, 8'd3, 3, 1'b0);
        fill(4, 1'b1);
        do_write(BASE + 32'd192, 4'h5, 8'd1, 4, 1'b0);
        do_read(BASE + 32'd160, 4'h6, 8'd7);

        // Index wraps past the top of the array
        fill(4, 1'b0);
        do_write(BASE + 32'(4094 * 8), 4'h7, 8'd3, 4, 1'b1);
        do_read(BASE + 32'(4094 * 8), 4'h8, 8'd3);
        do_read(BASE, 4'h8, 8'd1);

        // Randomized traffic with random ready back-pressure
        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            st = ($urandom_range(0, 3) == 0) ? 4088 + int'($urandom_range(0, 7)) : int'($urandom_range(0, 47));
            ra = BASE + 32'(st * 8);
            rl = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                fill(int'(rl) + 1, 1'b0);
                do_write(ra, 4'($urandom_range(0, 15)), rl, int'(rl) + 1, 1'b1);
            end else begin
                do_read(ra, 4'($urandom_range(0, 15)), rl);
            end
        end
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a read burst
        model_read(BASE + 32'd256, 4'hE, 8'd7);
        ar_addr = BASE + 32'd256; ar_id = 4'hE; ar_len = 8'd7; ar_valid = 1'b1;
        wait_ready(2);
        ar_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rq.delete();
        @(negedge clk);
        chk("rst_mid_r_valid", 64'(r_valid), 64'd0);
        reset_release();
        do_read(BASE + 32'd256, 4'hF, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
